matrix_inverse_streamer: RTL and testbench
==========================================

Name: matrix_inverse_streamer

Overview:
- Downstream consumer of the 5x5 rational matrix inverse stage.
- On `start`, snapshots the full inverse: N*N numerator words and N*N denominator words.
- Streams the entries out one per handshake in row-major order.
- Normalises sign so every emitted denominator is non-negative, and flags zero denominators.
- Decouples the inverse core from slower sinks such as a UART or display path.

Parameters:
- N, 5, matrix dimension (entries per row/column).
- W, 32, width of each numerator and denominator word (two's complement).

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  capture request; honoured only in IDLE.
- `inv_num`  input  N*N*W  packed numerators; entry k=r*N+c is at bits [W*k+W-1 : W*k].
- `inv_den`  input  N*N*W  packed denominators; same packing as `inv_num`.
- `out_valid`  output  1  current entry is valid.
- `out_ready`  input  1  sink accepts the entry; transfer happens when `out_valid` && `out_ready`.
- `out_num`  output  W  normalised numerator.
- `out_den`  output  W  normalised denominator.
- `out_row`  output  3  row index 0..N-1.
- `out_col`  output  3  column index 0..N-1.
- `out_last`  output  1  high with the final entry (row N-1, column N-1).
- `busy`  output  1  high in STREAM.
- `done`  output  1  one-cycle pulse after the last transfer.
- `div_zero_err`  output  1  sticky flag: some captured denominator was 0.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous, active-high.
- Reset values: state=IDLE; all outputs 0; snapshot registers cleared; row=0, col=0.
- States: IDLE, STREAM, DONE.
- IDLE, `start`=1:
  - Latch `inv_num` and `inv_den` into snapshot registers.
  - Clear `div_zero_err`; set row=0, col=0.
  - Go to STREAM next cycle.
  - Latency: `out_valid` rises the cycle after `start` is sampled.
- IDLE, `start`=0: stay in IDLE.
- STREAM:
  - `out_valid`=1 and `busy`=1.
  - Outputs are driven from the snapshot at (row, col).
  - Input ports are not looked at again until the next capture.
- Hold rule: while `out_valid` && !`out_ready`, `out_num`, `out_den`, `out_row`, `out_col` and `out_last` stay stable.
- Transfer (`out_valid` && `out_ready`) when not last:
  - col increments.
  - At col=N-1, col wraps to 0 and row increments.
- Transfer on the last entry: go to DONE; `out_valid` drops next cycle.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `out_valid`=0; return to IDLE.
- Throughput: one entry per cycle when `out_ready` is held high, so N*N=25 cycles of valid.
- Sign normalisation, applied combinationally on the snapshot entry:
  - If den<0 (MSB=1): out_num = -num, out_den = -den, two's-complement modulo 2^W.
  - -2^(W-1) maps to itself; no saturation.
  - Otherwise num and den pass through unchanged.
- Zero denominator:
  - The entry is still emitted with num unchanged and den=0.
  - `div_zero_err` sets on the cycle that entry is presented.
  - The flag stays high until the next accepted `start` or `reset`.
- `start` while in STREAM or DONE is ignored; the snapshot is unchanged.
- `reset` mid-stream: on the next edge, go to IDLE with all outputs 0; no `done` pulse.
- `reset` and `start` in the same cycle: `reset` wins.
- `out_ready` high while `out_valid`=0 has no effect.

Test Plan:
- Identity inverse (num=1 on the diagonal, else 0; den=1 everywhere), `out_ready` held 1 → `out_valid` for 25 consecutive cycles starting 1 cycle after `start`.
  - Diagonal entries emit 1/1, all others 0/1.
  - Row/col sequence runs (0,0)..(4,4); `out_last` only on (4,4).
  - `done` pulses exactly once, the cycle after the (4,4) transfer.
- Backpressure: `out_ready` pattern 1,0,0,1 repeating → outputs hold stable across the stalled cycles.
  - Exactly 25 transfers occur, none duplicated or skipped.
  - `busy` stays high until the last transfer.
- Sign normalisation:
  - Entry (2,3) = num 3, den -7 (0xFFFFFFF9) → emitted as -3 (0xFFFFFFFD) / 7.
  - Entry (0,1) = -5/-2 → emitted as 5/2.
  - Entry with den=0x80000000 → den emitted as 0x80000000.
- Zero denominator at (4,0):
  - `div_zero_err` is 0 during entries 0..19.
  - It goes to 1 when (4,0) is presented, with den output 0.
  - It stays 1 after `done` and clears on the next `start`.
- Snapshot isolation: change `inv_num`/`inv_den` and pulse `start` again mid-stream → emitted values still match the first capture.
  - The extra `start` is ignored and the stream completes normally.
- Reset mid-stream after 10 transfers → next cycle `out_valid`=0, `busy`=0, `done`=0, `div_zero_err`=0.
  - A following `start` restarts the stream at (0,0).

Source files
------------

// File: rtl/matrix_inverse_streamer.sv
// matrix_inverse_streamer: snapshots an NxN rational inverse on start and
// streams its entries out row-major over a valid/ready handshake.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   start                - capture request (honoured in IDLE only)
//   inv_num, inv_den     - packed N*N numerators / denominators, entry
//                          k = r*N+c at bits [W*k +: W]
//   out_valid/out_ready  - output handshake
//   out_num, out_den     - sign-normalised entry (den >= 0 unless -2^(W-1))
//   out_row, out_col     - entry coordinates
//   out_last             - final entry (N-1, N-1)
//   busy                 - streaming in progress
//   done                 - one-cycle pulse after the final transfer
//   div_zero_err         - sticky: a zero denominator was presented
module matrix_inverse_streamer #(
   parameter int N = 5,
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N*N*W-1:0] inv_num,
   input  logic [N*N*W-1:0] inv_den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_num,
   output logic [W-1:0]     out_den,
   output logic [2:0]       out_row,
   output logic [2:0]       out_col,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             div_zero_err
);

   localparam int NE = N * N;
   localparam int KW = $clog2(NE);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]  num_q [NE];
   logic [W-1:0]  den_q [NE];
   logic [2:0]    row_q, col_q;
   logic          err_q;
   logic [KW-1:0] k;
   logic [W-1:0]  cur_num, cur_den;
   logic          capture, xfer, at_last;
   logic          cur_zero, cur_neg;

   assign k       = KW'(row_q) * KW'(N) + KW'(col_q);
   assign cur_num = num_q[k];
   assign cur_den = den_q[k];
   assign at_last = (row_q == 3'(N - 1)) && (col_q == 3'(N - 1));
   assign cur_neg = cur_den[W-1];

   // Next-state and handshake decode
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      xfer      = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               xfer = 1'b1;
               if (at_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Snapshot: inputs are only looked at on an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NE; i++) begin
            num_q[i] <= '0;
            den_q[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NE; i++) begin
            num_q[i] <= inv_num[W*i +: W];
            den_q[i] <= inv_den[W*i +: W];
         end
      end
   end

   // Row-major position; left parked on the last entry after the stream
   always_ff @(posedge clk) begin
      if (reset || capture) begin
         row_q <= '0;
         col_q <= '0;
      end else if (xfer && !at_last) begin
         if (col_q == 3'(N - 1)) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
         end else begin
            col_q <= col_q + 3'd1;
         end
      end
   end

   // The flag must already be high on the cycle the zero entry is shown,
   // so the live condition is ORed with the sticky register.
   assign cur_zero = (state_q == STREAM) && (cur_den == '0);

   always_ff @(posedge clk) begin
      if (reset || capture) begin
         err_q <= 1'b0;
      end else if (cur_zero) begin
         err_q <= 1'b1;
      end
   end

   assign div_zero_err = err_q | cur_zero;

   // Data outputs are zero whenever no entry is being presented
   always_comb begin
      out_num  = '0;
      out_den  = '0;
      out_row  = '0;
      out_col  = '0;
      out_last = 1'b0;
      if (out_valid) begin
         out_num  = cur_neg ? (W'(0) - cur_num) : cur_num;
         out_den  = cur_neg ? (W'(0) - cur_den) : cur_den;
         out_row  = row_q;
         out_col  = col_q;
         out_last = at_last;
      end
   end

endmodule

// File: tb/tb_matrix_inverse_streamer.sv
// tb_matrix_inverse_streamer: table-driven matrices with a scoreboard of
// expected entries popped on each handshake.
module tb_matrix_inverse_streamer;

   localparam int N  = 5;
   localparam int W  = 32;
   localparam int NE = N * N;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [NE*W-1:0] inv_num;
   logic [NE*W-1:0] inv_den;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_num;
   logic [W-1:0]    out_den;
   logic [2:0]      out_row;
   logic [2:0]      out_col;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            div_zero_err;

   always #5 clk = ~clk;

   matrix_inverse_streamer #(.N(N), .W(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .inv_num      (inv_num),
      .inv_den      (inv_den),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_num      (out_num),
      .out_den      (out_den),
      .out_row      (out_row),
      .out_col      (out_col),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done),
      .div_zero_err (div_zero_err)
   );

   typedef struct {
      logic [W-1:0] num;
      logic [W-1:0] den;
      logic [W-1:0] exp_num;
      logic [W-1:0] exp_den;
   } vec_t;

   typedef struct {
      logic [W-1:0] num;
      logic [W-1:0] den;
      logic [2:0]   row;
      logic [2:0]   col;
      logic         last;
      logic         zero;
   } exp_t;

   vec_t ident  [NE];
   vec_t mixed  [NE];
   vec_t zfirst [NE];
   exp_t sb [$];

   int   errors = 0;
   int   checks = 0;
   logic err_m;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input int sel);
      vec_t v;
      exp_t e;
      sb.delete();
      for (int k = 0; k < NE; k++) begin
         case (sel)
            0:       v = ident[k];
            1:       v = mixed[k];
            default: v = zfirst[k];
         endcase
         inv_num[W*k +: W] = v.num;
         inv_den[W*k +: W] = v.den;
         e.num  = v.exp_num;
         e.den  = v.exp_den;
         e.row  = 3'(k / N);
         e.col  = 3'(k % N);
         e.last = (k == NE - 1);
         e.zero = (v.den == '0);
         sb.push_back(e);
      end
   endtask

   // bp: ready pattern 1,0,0,1; stop_after: reset after that many
   // transfers (-1 = run to completion); inject: extra start mid-stream
   task automatic run_stream(input int sel, input bit bp,
                             input int stop_after, input bit inject);
      int           cyc = 0;
      int           xf = 0;
      bit           fin = 0;
      bit           stalled = 0;
      exp_t         e;
      logic [W-1:0] pn, pd;
      logic [2:0]   pr, pc;
      @(negedge clk);
      load(sel);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      err_m = 1'b0;
      while (!fin && cyc < 200) begin
         start = 1'b0;
         chk("valid", out_valid, 1);
         chk("busy", busy, 1);
         chk("done_low", done, 0);
         e = sb[0];
         chk($sformatf("num[%0d,%0d]", e.row, e.col), out_num, e.num);
         chk($sformatf("den[%0d,%0d]", e.row, e.col), out_den, e.den);
         chk("row", out_row, e.row);
         chk("col", out_col, e.col);
         chk("last", out_last, e.last);
         err_m = err_m | e.zero;
         chk("div_zero_err", div_zero_err, err_m);
         if (stalled) begin
            chk("hold_num", out_num, pn);
            chk("hold_den", out_den, pd);
            chk("hold_row", out_row, pr);
            chk("hold_col", out_col, pc);
         end
         pn = out_num;
         pd = out_den;
         pr = out_row;
         pc = out_col;
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         stalled = !out_ready;
         if (out_ready) begin
            void'(sb.pop_front());
            xf++;
            if (inject && xf == 5) begin
               start   = 1'b1;
               inv_num = {NE{32'h1234_5678}};
               inv_den = {NE{32'h8765_4321}};
            end
            if (xf == stop_after) begin
               @(negedge clk);
               out_ready = 1'b0;
               reset = 1'b1;
               @(negedge clk);
               chk("rst_valid", out_valid, 0);
               chk("rst_busy", busy, 0);
               chk("rst_done", done, 0);
               chk("rst_dz", div_zero_err, 0);
               reset = 1'b0;
               sb.delete();
               return;
            end
            if (sb.size() == 0) fin = 1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d entries left", sb.size());
      end
      if (!bp) chk("valid_cycles", cyc, 25);
      chk("transfers", xf, 25);
      chk("done_pulse", done, 1);
      chk("done_valid", out_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_dz", div_zero_err, err_m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b0;
      chk("done_once", done, 0);
      chk("start_in_done", out_valid, 0);
      chk("idle_dz", div_zero_err, err_m);
   endtask

   initial begin
      for (int k = 0; k < NE; k++) begin
         ident[k].num     = (k / N == k % N) ? 32'd1 : 32'd0;
         ident[k].den     = 32'd1;
         ident[k].exp_num = ident[k].num;
         ident[k].exp_den = 32'd1;
         mixed[k].num     = 32'(k * 3) - 32'd10;
         mixed[k].den     = 32'(k + 2);
         mixed[k].exp_num = mixed[k].num;
         mixed[k].exp_den = mixed[k].den;
         zfirst[k]        = ident[k];
      end
      mixed[1]  = '{32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'd5, 32'd2};
      mixed[7]  = '{32'd9, 32'h8000_0000, 32'hFFFF_FFF7, 32'h8000_0000};
      mixed[13] = '{32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'd7};
      mixed[20] = '{32'd11, 32'd0, 32'd11, 32'd0};
      mixed[22] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
      zfirst[2].den     = 32'd0;
      zfirst[2].exp_den = 32'd0;

      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      inv_num   = '0;
      inv_den   = '0;
      err_m     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero_err, 0);
      chk("rst_num", out_num, 0);
      chk("rst_den", out_den, 0);
      chk("rst_row", out_row, 0);
      chk("rst_col", out_col, 0);
      chk("rst_last", out_last, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_valid", out_valid, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("ready_no_valid", out_valid, 0);
      chk("ready_no_busy", busy, 0);
      out_ready = 1'b0;

      run_stream(0, 1'b0, -1, 1'b0);
      run_stream(1, 1'b1, -1, 1'b1);
      run_stream(0, 1'b0, -1, 1'b0);
      run_stream(2, 1'b0, 10, 1'b0);
      run_stream(2, 1'b0, -1, 1'b0);

      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      chk("rst_beats_start", out_valid, 0);
      @(negedge clk);
      chk("rst_beats_start2", out_valid, 0);
      chk("rst_beats_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
